// File: rtl/hand_collector.sv
// rtl/hand_collector.sv - collects PLAYERS janken hands per round, judges the winners and drives the display
//
// Purpose: capture one 2-bit hand per debounced button press, judge the round
// once PLAYERS hands are in, and hold the result until the round is cleared.
//
// Ports:
//   clk          - single clock, all state on rising edge
//   rst_         - asynchronous active-low reset
//   pon          - display mode: 1 shows the collected buffer, 0 shows the live hand
//   gtp_         - active-low asynchronous capture button
//   clr_         - active-low asynchronous round-clear button
//   selecter_in  - live hand (00 gu, 01 choki, 10 pa, 11 invalid)
//   g_data_out   - registered display data
//   count        - hands captured this round
//   winners      - one bit per slot holding the winning hand
//   draw         - round judged a draw
//   done         - one-cycle pulse when the judgement is registered
//   err          - one-cycle pulse on a capture attempt with an invalid hand
module hand_collector #(
  parameter int PLAYERS = 3
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           pon,
  input  logic                           gtp_,
  input  logic                           clr_,
  input  logic [1:0]                     selecter_in,
  output logic [2*PLAYERS-1:0]           g_data_out,
  output logic [$clog2(PLAYERS+1)-1:0]   count,
  output logic [PLAYERS-1:0]             winners,
  output logic                           draw,
  output logic                           done,
  output logic                           err
);

  localparam int CW = $clog2(PLAYERS + 1);
  localparam int BW = 2 * PLAYERS;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    JUDGE   = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     hand_buf_q, hand_buf_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PLAYERS-1:0] winners_q, winners_d;
  logic              draw_q, draw_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BW-1:0]     g_data_q, g_data_d;

  // Button synchronisers, history and arm flags
  logic gtp_s1_q, gtp_s2_q, gtp_h_q, gtp_arm_q;
  logic clr_s1_q, clr_s2_q, clr_h_q, clr_arm_q;
  logic [1:0] settle_q;
  logic gtp_fall, clr_fall;

  // A button is armed only once it has been seen released after the
  // synchroniser has flushed its reset value; a button held low through
  // reset release therefore cannot produce an event.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      gtp_s1_q  <= 1'b1;
      gtp_s2_q  <= 1'b1;
      gtp_h_q   <= 1'b1;
      gtp_arm_q <= 1'b0;
      clr_s1_q  <= 1'b1;
      clr_s2_q  <= 1'b1;
      clr_h_q   <= 1'b1;
      clr_arm_q <= 1'b0;
      settle_q  <= 2'd0;
    end else begin
      gtp_s1_q  <= gtp_;
      gtp_s2_q  <= gtp_s1_q;
      gtp_h_q   <= gtp_s2_q;
      clr_s1_q  <= clr_;
      clr_s2_q  <= clr_s1_q;
      clr_h_q   <= clr_s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && gtp_s2_q) gtp_arm_q <= 1'b1;
      if (settle_q == 2'd3 && clr_s2_q) clr_arm_q <= 1'b1;
    end
  end

  assign gtp_fall = gtp_arm_q & gtp_h_q & ~gtp_s2_q;
  assign clr_fall = clr_arm_q & clr_h_q & ~clr_s2_q;

  // Judgement of the full buffer
  logic               has_g, has_c, has_p, two_hands;
  logic [1:0]         win_hand;
  logic [PLAYERS-1:0] judge_winners;

  always_comb begin
    has_g = 1'b0;
    has_c = 1'b0;
    has_p = 1'b0;
    for (int i = 0; i < PLAYERS; i++) begin
      if (hand_buf_q[2*i +: 2] == 2'b00) has_g = 1'b1;
      if (hand_buf_q[2*i +: 2] == 2'b01) has_c = 1'b1;
      if (hand_buf_q[2*i +: 2] == 2'b10) has_p = 1'b1;
    end
    two_hands = (has_g & has_c & ~has_p) | (has_c & has_p & ~has_g) |
                (has_p & has_g & ~has_c);
    if (has_g && has_c)      win_hand = 2'b00;
    else if (has_c && has_p) win_hand = 2'b01;
    else                     win_hand = 2'b10;
    judge_winners = '0;
    for (int i = 0; i < PLAYERS; i++) begin
      judge_winners[i] = two_hands && (hand_buf_q[2*i +: 2] == win_hand);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    hand_buf_d = hand_buf_q;
    count_d    = count_q;
    winners_d  = winners_q;
    draw_d     = draw_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (clr_fall) begin
      // Clear has priority over any capture or judgement on the same edge.
      state_d    = COLLECT;
      hand_buf_d = '0;
      count_d    = '0;
      winners_d  = '0;
      draw_d     = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (gtp_fall) begin
            if (selecter_in == 2'b11) begin
              err_d = 1'b1;
            end else begin
              hand_buf_d = {hand_buf_q[BW-3:0], selecter_in};
              count_d    = count_q + CW'(1);
              if (count_q == CW'(PLAYERS - 1)) state_d = JUDGE;
            end
          end
        end
        JUDGE: begin
          winners_d = judge_winners;
          draw_d    = ~two_hands;
          done_d    = 1'b1;
          state_d   = RESULT;
        end
        RESULT: ;
        default: state_d = COLLECT;
      endcase
    end

    g_data_d = pon ? hand_buf_q : {{(BW-2){1'b0}}, selecter_in};
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= COLLECT;
      hand_buf_q <= '0;
      count_q    <= '0;
      winners_q  <= '0;
      draw_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      g_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      hand_buf_q <= hand_buf_d;
      count_q    <= count_d;
      winners_q  <= winners_d;
      draw_q     <= draw_d;
      done_q     <= done_d;
      err_q      <= err_d;
      g_data_q   <= g_data_d;
    end
  end

  assign g_data_out = g_data_q;
  assign count      = count_q;
  assign winners    = winners_q;
  assign draw       = draw_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hand_collector.sv
// tb/tb_hand_collector.sv - directed self-checking bench for hand_collector (PLAYERS=3 and PLAYERS=8)
module tb_hand_collector;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic pon = 1'b0;
  logic gtp_ = 1'b1;
  logic clr_ = 1'b1;
  logic [1:0] selecter_in = 2'b00;

  logic [5:0]  g3;
  logic [1:0]  count3;
  logic [2:0]  win3;
  logic        draw3, done3, err3;
  logic [15:0] g8;
  logic [3:0]  count8;
  logic [7:0]  win8;
  logic        draw8, done8, err8;

  int checks = 0;
  int errors = 0;
  int done3_cnt = 0;
  int err3_cnt = 0;
  int done8_cnt = 0;

  always #5 clk = ~clk;

  hand_collector #(.PLAYERS(3)) u3 (
    .clk(clk), .rst_(rst_), .pon(pon), .gtp_(gtp_), .clr_(clr_),
    .selecter_in(selecter_in), .g_data_out(g3), .count(count3),
    .winners(win3), .draw(draw3), .done(done3), .err(err3)
  );

  hand_collector #(.PLAYERS(8)) u8 (
    .clk(clk), .rst_(rst_), .pon(pon), .gtp_(gtp_), .clr_(clr_),
    .selecter_in(selecter_in), .g_data_out(g8), .count(count8),
    .winners(win8), .draw(draw8), .done(done8), .err(err8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample pulse outputs away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done3) done3_cnt++;
    if (err3)  err3_cnt++;
    if (done8) done8_cnt++;
  endtask

  task automatic press(input logic [1:0] sel);
    selecter_in = sel;
    gtp_ = 1'b0;
    repeat (3) tick();
    gtp_ = 1'b1;
    repeat (3) tick();
  endtask

  task automatic clear_round();
    clr_ = 1'b0;
    repeat (3) tick();
    clr_ = 1'b1;
    repeat (3) tick();
  endtask

  int d0, e0;

  initial begin
    // Reset state
    #2;
    check("rst_count3", count3, 0);
    check("rst_g3", g3, 0);
    check("rst_win3", {draw3, win3}, 0);
    check("rst_pulses", {done3, err3}, 0);
    #10 rst_ = 1'b1;
    repeat (6) tick();

    // Capture 00,01,01 with count stepping 1,2,3
    selecter_in = 2'b00; gtp_ = 1'b0;
    repeat (2) tick();
    check("no_early_capture", count3, 0);
    tick();
    check("count_1", count3, 1);
    gtp_ = 1'b1; repeat (3) tick();
    press(2'b01);
    check("count_2", count3, 2);
    selecter_in = 2'b01; gtp_ = 1'b0;
    repeat (3) tick();
    check("count_3", count3, 3);
    check("done_not_yet", done3_cnt, 0);
    tick();
    check("done_pulse", done3, 1);
    check("winners_gu", win3, 3'b100);
    check("draw_0", draw3, 0);
    tick();
    check("done_single", done3, 0);
    gtp_ = 1'b1; repeat (3) tick();

    // Display mode
    selecter_in = 2'b10; pon = 1'b0; tick();
    check("g_live", g3, 6'b000010);
    pon = 1'b1; tick();
    check("g_buf", g3, 6'b000101);

    // Press in RESULT is ignored
    e0 = err3_cnt;
    press(2'b10);
    check("result_count", count3, 3);
    check("result_win", {draw3, win3}, 4'b0100);
    check("result_no_err", err3_cnt, e0);
    check("result_buf", g3, 6'b000101);
    check("done_total", done3_cnt, 1);

    // Clear
    clear_round();
    check("clr_count", count3, 0);
    check("clr_result", {draw3, win3}, 0);
    tick();
    check("clr_buf", g3, 0);

    // Three distinct hands -> draw
    press(2'b00); press(2'b01); press(2'b10); tick();
    check("draw3_distinct", {draw3, win3}, 4'b1000);
    clear_round();
    // One hand -> draw
    press(2'b10); press(2'b10); press(2'b10); tick();
    check("draw1_same", {draw3, win3}, 4'b1000);
    // pa beats gu: 10,00,10 -> slots 2 and 0 win
    clear_round();
    press(2'b10); press(2'b00); press(2'b10); tick();
    check("winners_pa", {draw3, win3}, 4'b0101);
    clear_round();

    // Invalid hand -> one err pulse, no capture
    e0 = err3_cnt;
    press(2'b11);
    check("err_pulse", err3_cnt, e0 + 1);
    check("err_count", count3, 0);

    // Long hold -> single capture
    selecter_in = 2'b00; gtp_ = 1'b0;
    repeat (100) tick();
    gtp_ = 1'b1; repeat (3) tick();
    check("hold_one", count3, 1);

    // clr and gtp falling together: clr wins
    e0 = err3_cnt;
    selecter_in = 2'b01; gtp_ = 1'b0; clr_ = 1'b0;
    repeat (3) tick();
    gtp_ = 1'b1; clr_ = 1'b1; repeat (3) tick();
    check("clrgtp_count", count3, 0);
    check("clrgtp_buf", g3, 0);
    check("clrgtp_no_err", err3_cnt, e0);

    // clr acting while in JUDGE suppresses done
    press(2'b00); press(2'b01);
    d0 = done3_cnt;
    selecter_in = 2'b01; gtp_ = 1'b0;
    tick();
    clr_ = 1'b0;
    repeat (2) tick();
    check("judge_entered", count3, 3);
    tick();
    gtp_ = 1'b1; clr_ = 1'b1; repeat (4) tick();
    check("judge_clr_nodone", done3_cnt, d0);
    check("judge_clr_count", count3, 0);
    check("judge_clr_result", {draw3, win3}, 0);

    // Button held low across reset release
    gtp_ = 1'b0;
    rst_ = 1'b0; #3; rst_ = 1'b1;
    repeat (10) tick();
    check("held_reset_none", count3, 0);
    gtp_ = 1'b1; repeat (3) tick();
    press(2'b00);
    check("held_reset_then", count3, 1);
    clear_round();

    // PLAYERS=8: reset mid-round discards the round
    d0 = done8_cnt;
    press(2'b01); press(2'b01); press(2'b10); press(2'b01); press(2'b10);
    check("p8_count5", count8, 5);
    rst_ = 1'b0; #2;
    check("p8_rst_out", {count8, win8, draw8, done8, err8}, 0);
    check("p8_rst_g", g8, 0);
    rst_ = 1'b1;
    repeat (10) tick();
    check("p8_no_done", done8_cnt, d0);
    check("p8_count0", count8, 0);
    press(2'b01); press(2'b01); press(2'b10); press(2'b01);
    press(2'b10); press(2'b10); press(2'b01); press(2'b10);
    check("p8_count8", count8, 8);
    check("p8_done", done8_cnt, d0 + 1);
    check("p8_winners", {draw8, win8}, 9'h0D2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
